// File: rtl/spi_word_rx_pkg.sv
// Shared types and defaults for the SPI word receiver.
package spi_pkg;

    // Default word length and synchronizer depth.
    localparam int unsigned SPI_WIDTH       = 16;
    localparam int unsigned SPI_SYNC_STAGES = 2;

    // Frame state: IDLE between frames, SHIFT while nCS is asserted.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_word_rx_if.sv
// Pin and word-side signals of the SPI word receiver.
// slave: the receiver itself; master: the host pins plus the loader side.
interface spi_word_rx_if #(
    parameter int unsigned WIDTH = spi_pkg::SPI_WIDTH
);

    logic             nCS;
    logic             SCK;
    logic             MOSI;
    logic             MISO;
    logic [WIDTH-1:0] tx_word;
    logic [WIDTH-1:0] shiftreg;
    logic             data_ready;
    logic             new_transfer;
    logic             transfer_done;
    logic             chip_selected;

    modport slave (
        input  nCS, SCK, MOSI, tx_word,
        output MISO, shiftreg, data_ready, new_transfer, transfer_done, chip_selected
    );

    modport master (
        output nCS, SCK, MOSI, tx_word,
        input  MISO, shiftreg, data_ready, new_transfer, transfer_done, chip_selected
    );

endinterface

// File: rtl/spi_word_rx_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, followed by one more
// registered copy used for edge detection. level, rise and fall are all
// registered and mutually aligned (STAGES+1 cycles after the pin edge).
module sync_edge #(
    parameter int unsigned STAGES     = 2,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              level_q;
    logic              rise_q;
    logic              fall_q;

    // Synchronizer chain, delayed copy and registered edge strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {STAGES{IDLE_LEVEL}};
            level_q <= IDLE_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d};
            level_q <= sync_q[STAGES-1];
            rise_q  <= sync_q[STAGES-1] & ~level_q;
            fall_q  <= ~sync_q[STAGES-1] & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0 slave front end: synchronizes nCS/SCK/MOSI into clk, assembles
// MSB-first words, and shifts tx_word out on MISO for host readback.
module spi_word_rx
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = SPI_WIDTH,
    parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic           clk,
    input  logic           reset_n,
    spi_word_rx_if.slave   bus
);

    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0]    LAST_BIT    = CNT_W'(WIDTH - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

    // Synchronized pin views.
    logic cs_level;          // 1 = nCS deasserted
    logic cs_rise;
    logic cs_fall;
    logic sck_level_unused;
    logic sck_rise;
    logic sck_fall;
    logic mosi_level;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    // Arming after reset.
    logic [SETTLE_W-1:0] settle_q;
    logic                armed_q;
    logic                cs_start;

    // FSM.
    spi_state_t state_q;
    spi_state_t state_d;
    logic       new_transfer_c;
    logic       transfer_done_c;
    logic       load_tx;
    logic       clear_cnt;
    logic       sample;
    logic       shift_out;
    logic       word_done;

    // Datapath.
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rx_sh_q;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_sh_q;
    logic [WIDTH-1:0] shiftreg_q;
    logic             data_ready_q;

    sync_edge #(
        .STAGES     (SYNC_STAGES),
        .IDLE_LEVEL (1'b1)
    ) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.nCS),
        .level   (cs_level),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    sync_edge #(
        .STAGES     (SYNC_STAGES),
        .IDLE_LEVEL (1'b0)
    ) u_sync_sck (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.SCK),
        .level   (sck_level_unused),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    // Same depth as SCK so the sampled MOSI lines up with sck_rise.
    sync_edge #(
        .STAGES     (SYNC_STAGES),
        .IDLE_LEVEL (1'b0)
    ) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.MOSI),
        .level   (mosi_level),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    // A frame already running when reset is released must be ignored: the
    // synchronizers come out of reset at the idle level, so a held-low nCS
    // would look like a fresh fall. Accept nCS falls only once nCS has been
    // seen high after the synchronizer pipeline has flushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != SETTLE_DONE) begin
                settle_q <= settle_q + SETTLE_W'(1);
            end
            if ((settle_q == SETTLE_DONE) && cs_level) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign cs_start = cs_fall & armed_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, framing strobes and datapath controls; nCS rise beats SCK.
    always_comb begin
        state_d         = state_q;
        new_transfer_c  = 1'b0;
        transfer_done_c = 1'b0;
        load_tx         = 1'b0;
        clear_cnt       = 1'b0;
        sample          = 1'b0;
        shift_out       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_start) begin
                    state_d        = SHIFT;
                    new_transfer_c = 1'b1;
                    load_tx        = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d         = IDLE;
                    transfer_done_c = 1'b1;
                    clear_cnt       = 1'b1;
                end else if (sck_rise) begin
                    sample = 1'b1;
                end else if (sck_fall) begin
                    shift_out = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        word_done = sample && (cnt_q == LAST_BIT);
    end

    assign rx_next = {rx_sh_q[WIDTH-2:0], mosi_level};

    // Bit counter, rx/tx shifters, completed-word register and ready strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            rx_sh_q      <= '0;
            tx_sh_q      <= '0;
            shiftreg_q   <= '0;
            data_ready_q <= 1'b0;
        end else begin
            data_ready_q <= word_done;
            if (load_tx) begin
                cnt_q   <= '0;
                tx_sh_q <= bus.tx_word;
            end else if (clear_cnt) begin
                cnt_q <= '0;
            end else if (sample) begin
                rx_sh_q <= rx_next;
                if (word_done) begin
                    cnt_q      <= '0;
                    shiftreg_q <= rx_next;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (shift_out) begin
                if (cnt_q != '0) begin
                    tx_sh_q <= {tx_sh_q[WIDTH-2:0], 1'b0};
                end else begin
                    tx_sh_q <= bus.tx_word;
                end
            end
        end
    end

    assign bus.MISO          = (state_q == SHIFT) ? tx_sh_q[WIDTH-1] : 1'b0;
    assign bus.shiftreg      = shiftreg_q;
    assign bus.data_ready    = data_ready_q;
    assign bus.new_transfer  = new_transfer_c;
    assign bus.transfer_done = transfer_done_c;
    assign bus.chip_selected = ~cs_level;

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed bench for spi_word_rx: framing, multi-word, partial word, MISO
// readback, mid-frame reset and a random stream at the SCK rate limit.
module tb_spi_word_rx;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    spi_word_rx_if #(.WIDTH(W)) bus ();

    spi_word_rx #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Strobe monitor: counts and captured words, sampled on the falling edge.
    int         nt_cnt = 0;
    int         td_cnt = 0;
    int         dr_cnt = 0;
    int         dr_long = 0;
    logic       dr_prev = 1'b0;
    logic [W-1:0] got_w [0:511];

    always @(negedge clk) begin
        if (bus.new_transfer === 1'b1) nt_cnt <= nt_cnt + 1;
        if (bus.transfer_done === 1'b1) td_cnt <= td_cnt + 1;
        if (bus.data_ready === 1'b1) begin
            got_w[dr_cnt % 512] <= bus.shiftreg;
            dr_cnt <= dr_cnt + 1;
            if (dr_prev) dr_long <= dr_long + 1;
        end
        dr_prev <= (bus.data_ready === 1'b1);
    end

    task automatic send_bit(input logic b, input int half, output logic miso_s);
        bus.MOSI = b;
        repeat (half) @(negedge clk);
        bus.SCK = 1'b1;
        miso_s = bus.MISO;
        repeat (half) @(negedge clk);
        bus.SCK = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int half, output logic [W-1:0] rd);
        logic b;
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(w[i], half, b);
            rd[i] = b;
        end
    endtask

    task automatic frame_begin();
        bus.nCS = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        bus.nCS = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.shiftreg !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_shiftreg got %h want 0000", bus.shiftreg);
        end
        vectors++;
        if ({bus.data_ready, bus.new_transfer, bus.transfer_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_strobes got %b want 000",
                     {bus.data_ready, bus.new_transfer, bus.transfer_done});
        end
        vectors++;
        if ({bus.chip_selected, bus.MISO} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_cs_miso got %b want 00", {bus.chip_selected, bus.MISO});
        end
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int nt0, td0, dr0;
        logic [W-1:0] w;
        logic b;
        w = 16'hA55A;
        nt0 = nt_cnt; td0 = td_cnt; dr0 = dr_cnt;
        bus.nCS = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.chip_selected !== 1'b0) begin
            miscompares++;
            $display("FAIL single_cs_early got %b want 0", bus.chip_selected);
        end
        @(negedge clk);
        vectors++;
        if ({bus.chip_selected, bus.new_transfer} !== 2'b11) begin
            miscompares++;
            $display("FAIL single_cs_latency got %b want 11", {bus.chip_selected, bus.new_transfer});
        end
        @(negedge clk);
        vectors++;
        if (bus.new_transfer !== 1'b0) begin
            miscompares++;
            $display("FAIL single_nt_width got %b want 0", bus.new_transfer);
        end
        repeat (4) @(negedge clk);
        for (int i = W - 1; i >= 1; i--) send_bit(w[i], 8, b);
        bus.MOSI = w[0];
        repeat (8) @(negedge clk);
        bus.SCK = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_dr_early got %b want 0", bus.data_ready);
        end
        @(negedge clk);
        vectors++;
        if ({bus.data_ready, bus.shiftreg} !== {1'b1, 16'hA55A}) begin
            miscompares++;
            $display("FAIL single_dr_word got %b/%h want 1/a55a", bus.data_ready, bus.shiftreg);
        end
        @(negedge clk);
        vectors++;
        if (bus.data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_dr_width got %b want 0", bus.data_ready);
        end
        repeat (3) @(negedge clk);
        bus.SCK = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if (bus.chip_selected !== 1'b1) begin
            miscompares++;
            $display("FAIL single_cs_held got %b want 1", bus.chip_selected);
        end
        bus.nCS = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.transfer_done, bus.chip_selected} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_td got %b want 10", {bus.transfer_done, bus.chip_selected});
        end
        repeat (8) @(negedge clk);
        vectors++;
        if ({nt_cnt - nt0, td_cnt - td0, dr_cnt - dr0} !== {32'd1, 32'd1, 32'd1}) begin
            miscompares++;
            $display("FAIL single_counts got nt=%0d td=%0d dr=%0d want 1 1 1",
                     nt_cnt - nt0, td_cnt - td0, dr_cnt - dr0);
        end
    endtask

    task automatic test_multi_word();
        logic [W-1:0] exp_w [3];
        logic [W-1:0] rd;
        int nt0, td0, dr0;
        exp_w[0] = 16'h0001; exp_w[1] = 16'h8000; exp_w[2] = 16'hFFFF;
        nt0 = nt_cnt; td0 = td_cnt; dr0 = dr_cnt;
        frame_begin();
        for (int k = 0; k < 3; k++) send_word(exp_w[k], 4, rd);
        frame_end();
        vectors++;
        if ({nt_cnt - nt0, td_cnt - td0, dr_cnt - dr0} !== {32'd1, 32'd1, 32'd3}) begin
            miscompares++;
            $display("FAIL multi_counts got nt=%0d td=%0d dr=%0d want 1 1 3",
                     nt_cnt - nt0, td_cnt - td0, dr_cnt - dr0);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_w[(dr0 + k) % 512] !== exp_w[k]) begin
                miscompares++;
                $display("FAIL multi_word%0d got %h want %h", k, got_w[(dr0 + k) % 512], exp_w[k]);
            end
        end
    endtask

    task automatic test_partial_word();
        logic [W-1:0] rd;
        logic [8:0] tail;
        logic b;
        int td0, dr0;
        tail = 9'b1_0110_1001;
        td0 = td_cnt; dr0 = dr_cnt;
        frame_begin();
        send_word(16'h1234, 4, rd);
        for (int i = 8; i >= 0; i--) send_bit(tail[i], 4, b);
        frame_end();
        vectors++;
        if ({td_cnt - td0, dr_cnt - dr0} !== {32'd1, 32'd1}) begin
            miscompares++;
            $display("FAIL partial_counts got td=%0d dr=%0d want 1 1", td_cnt - td0, dr_cnt - dr0);
        end
        vectors++;
        if (got_w[dr0 % 512] !== 16'h1234) begin
            miscompares++;
            $display("FAIL partial_word got %h want 1234", got_w[dr0 % 512]);
        end
        vectors++;
        if (bus.shiftreg !== 16'h1234) begin
            miscompares++;
            $display("FAIL partial_hold got %h want 1234", bus.shiftreg);
        end
    endtask

    task automatic test_miso_readback();
        logic [W-1:0] rd0, rd1;
        int dr0;
        dr0 = dr_cnt;
        bus.tx_word = 16'hC3A5;
        frame_begin();
        bus.tx_word = 16'h3C69;
        send_word(16'h0F0F, 8, rd0);
        send_word(16'hF0F0, 8, rd1);
        frame_end();
        vectors++;
        if (rd0 !== 16'hC3A5) begin
            miscompares++;
            $display("FAIL miso_slot0 got %h want c3a5", rd0);
        end
        vectors++;
        if (rd1 !== 16'h3C69) begin
            miscompares++;
            $display("FAIL miso_slot1 got %h want 3c69", rd1);
        end
        vectors++;
        if ({got_w[dr0 % 512], got_w[(dr0 + 1) % 512]} !== {16'h0F0F, 16'hF0F0}) begin
            miscompares++;
            $display("FAIL miso_rx got %h %h want 0f0f f0f0", got_w[dr0 % 512], got_w[(dr0 + 1) % 512]);
        end
        vectors++;
        if (bus.MISO !== 1'b0) begin
            miscompares++;
            $display("FAIL miso_idle got %b want 0", bus.MISO);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] rd;
        logic [6:0] head;
        logic [24:0] rest;
        logic b;
        int nt0, td0, dr0;
        head = 7'b1100101;
        rest = 25'h1ABCDEF;
        frame_begin();
        for (int i = 6; i >= 0; i--) send_bit(head[i], 4, b);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.shiftreg, bus.data_ready, bus.new_transfer, bus.transfer_done,
             bus.chip_selected, bus.MISO} !== {16'h0000, 5'b00000}) begin
            miscompares++;
            $display("FAIL midreset_outputs got %h/%b want 0000/00000", bus.shiftreg,
                     {bus.data_ready, bus.new_transfer, bus.transfer_done, bus.chip_selected, bus.MISO});
        end
        reset_n = 1'b1;
        @(negedge clk);
        nt0 = nt_cnt; td0 = td_cnt; dr0 = dr_cnt;
        for (int i = 24; i >= 0; i--) send_bit(rest[i], 4, b);
        frame_end();
        frame_begin();
        send_word(16'h5A5A, 4, rd);
        frame_end();
        vectors++;
        if ({nt_cnt - nt0, td_cnt - td0, dr_cnt - dr0} !== {32'd1, 32'd1, 32'd1}) begin
            miscompares++;
            $display("FAIL midreset_counts got nt=%0d td=%0d dr=%0d want 1 1 1",
                     nt_cnt - nt0, td_cnt - td0, dr_cnt - dr0);
        end
        vectors++;
        if (got_w[dr0 % 512] !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL midreset_word got %h want 5a5a", got_w[dr0 % 512]);
        end
    endtask

    task automatic test_sck_limit();
        logic [W-1:0] exp_w [64];
        logic [W-1:0] rd;
        int dr0;
        int bad;
        dr0 = dr_cnt;
        bad = 0;
        for (int k = 0; k < 64; k++) exp_w[k] = W'($urandom);
        frame_begin();
        for (int k = 0; k < 64; k++) send_word(exp_w[k], 3, rd);
        frame_end();
        vectors++;
        if (dr_cnt - dr0 !== 64) begin
            miscompares++;
            $display("FAIL limit_count got %0d want 64", dr_cnt - dr0);
        end
        for (int k = 0; k < 64; k++) begin
            vectors++;
            if (got_w[(dr0 + k) % 512] !== exp_w[k]) begin
                miscompares++;
                bad++;
                if (bad <= 8) begin
                    $display("FAIL limit_word%0d got %h want %h", k, got_w[(dr0 + k) % 512], exp_w[k]);
                end
            end
        end
        vectors++;
        if (dr_long !== 0) begin
            miscompares++;
            $display("FAIL dr_pulse_width got %0d long strobes want 0", dr_long);
        end
    endtask

    initial begin
        bus.nCS = 1'b1;
        bus.SCK = 1'b0;
        bus.MOSI = 1'b0;
        bus.tx_word = '0;
        test_reset();
        test_single_frame();
        test_multi_word();
        test_partial_word();
        test_miso_readback();
        test_reset_mid_word();
        test_sck_limit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
